led_scan_ctrl: RTL and testbench

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/led_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_led_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl -- eight-digit multiplexed LED scan controller.
//
// A prescaler divides clk down to one tick per digit slot. Each tick advances
// the 3-bit digit scan index (LED_clk). New display data is accepted through a
// one-entry valid/ready buffer and swapped into disp_data only at the frame
// boundary (tick while LED_clk == 7), so a frame never shows a mix of old and
// new digits.
//
// Optional feature macro: LED_SCAN_FREEZE_EN
//   Adds input 'freeze'. While freeze=1, frame-boundary transfers are held off
//   (pending data is kept); scanning and frame_done carry on as normal.
//
// Parameters
//   PRESCALE    clk cycles per digit slot, 1 .. 2**20
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   data_in     eight hex nibbles to display, nibble 0 = data_in[3:0]
//   data_valid  data_in is offered this cycle
//   freeze      (LED_SCAN_FREEZE_EN only) suppress boundary transfers
//   data_ready  buffer can accept data_in this cycle (combinational)
//   LED_clk     current digit scan index
//   disp_data   value currently being scanned out
//   frame_done  one-cycle pulse after each completed 8-digit frame

module led_scan_ctrl #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
`ifdef LED_SCAN_FREEZE_EN
  input  logic        freeze,
`endif
  output logic        data_ready,
  output logic [2:0]  LED_clk,
  output logic [31:0] disp_data,
  output logic        frame_done
);

  localparam int unsigned    CW       = $clog2(PRESCALE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q,        cnt_d;
  logic [2:0]    led_q,        led_d;
  logic [31:0]   disp_q,       disp_d;
  logic [31:0]   pend_data_q,  pend_data_d;
  logic          pend_valid_q, pend_valid_d;
  logic          frame_done_q, frame_done_d;

  logic tick;
  logic boundary;
  logic accept;
  logic xfer_en;

`ifdef LED_SCAN_FREEZE_EN
  assign xfer_en = !freeze;
`else
  assign xfer_en = 1'b1;
`endif

  // With PRESCALE=1 the counter is stuck at 0 == CNT_LAST, so tick is
  // asserted every cycle.
  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (led_q == 3'd7);

  // NOTE: data_ready is the only combinational output; it is derived from
  // registered state plus rst so it reads 0 throughout reset and 1 on the
  // very first cycle after reset is released.
  assign data_ready = !pend_valid_q && !rst;
  assign accept     = data_valid && data_ready;

  // NOTE: every next-state variable gets its hold value first so that no
  // path through this block leaves one unassigned (which would infer a latch).
  always_comb begin
    cnt_d        = cnt_q;
    led_d        = led_q;
    disp_d       = disp_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    frame_done_d = boundary;

    if (tick) begin
      cnt_d = '0;
      led_d = led_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Swap in pending data only at a frame boundary; the new value first
    // shows on the same edge LED_clk wraps to 0.
    if (boundary && pend_valid_q && xfer_en) begin
      disp_d       = pend_data_q;
      pend_valid_d = 1'b0;
    end

    // accept implies pend_valid_q == 0, so it never collides with the
    // transfer above. Data taken on a boundary cycle waits a full frame.
    if (accept) begin
      pend_data_d  = data_in;
      pend_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The pending
  // data word is reset too, so a value discarded by reset can never reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      led_q        <= '0;
      disp_q       <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      led_q        <= led_d;
      disp_q       <= disp_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign LED_clk    = led_q;
  assign disp_data  = disp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with PRESCALE=4 (one frame = 32 cycles).
// Cycle n below means "state just after the n-th rising edge since the most
// recent reset release"; frame boundaries fall on cycles 32, 64, 96, ...

module tb_led_scan_ctrl;

  localparam int unsigned PRESCALE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [2:0]  LED_clk;
  logic [31:0] disp_data;
  logic        frame_done;
`ifdef LED_SCAN_FREEZE_EN
  logic        freeze;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  led_scan_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
`ifdef LED_SCAN_FREEZE_EN
    .freeze     (freeze),
`endif
    .data_ready (data_ready),
    .LED_clk    (LED_clk),
    .disp_data  (disp_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge number n; inputs are changed
  // afterwards so they are stable well before the next edge.
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
`ifdef LED_SCAN_FREEZE_EN
    freeze     = 1'b0;
`endif

    // ---------------- reset: 2 cycles ----------------
    step_to(2);
    check("rst_ready",  {31'b0, data_ready}, 32'd0);
    check("rst_led",    {29'b0, LED_clk},    32'd0);
    check("rst_disp",   disp_data,           32'h0);
    check("rst_fdone",  {31'b0, frame_done}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    #1;
    check("ready_first", {31'b0, data_ready}, 32'd1);

    // ---------------- idle scan ----------------
    step_to(3);  check("led_c3",  {29'b0, LED_clk}, 32'd0);
    step_to(4);  check("led_c4",  {29'b0, LED_clk}, 32'd1);
    step_to(8);  check("led_c8",  {29'b0, LED_clk}, 32'd2);
    step_to(28); check("led_c28", {29'b0, LED_clk}, 32'd7);
    step_to(31); check("fd_c31",  {31'b0, frame_done}, 32'd0);
    step_to(32);
    check("led_c32",  {29'b0, LED_clk},    32'd0);
    check("fd_c32",   {31'b0, frame_done}, 32'd1);
    check("disp_c32", disp_data,           32'h0);
    step_to(33); check("fd_c33", {31'b0, frame_done}, 32'd0);
    step_to(63); check("fd_c63", {31'b0, frame_done}, 32'd0);
    step_to(64); check("fd_c64", {31'b0, frame_done}, 32'd1);
    step_to(65); check("fd_c65", {31'b0, frame_done}, 32'd0);

    // ---------------- single transfer ----------------
    step_to(69);
    data_in    = 32'h12345678;
    data_valid = 1'b1;
    step_to(70);
    data_valid = 1'b0;
    data_in    = 32'hDEADBEEF;
    check("ready_drop", {31'b0, data_ready}, 32'd0);
    check("disp_hold",  disp_data,           32'h0);
    step_to(95);
    check("disp_c95",  disp_data,           32'h0);
    check("ready_c95", {31'b0, data_ready}, 32'd0);
    step_to(96);
    check("disp_c96",  disp_data,           32'h12345678);
    check("led_c96",   {29'b0, LED_clk},    32'd0);
    check("ready_c96", {31'b0, data_ready}, 32'd1);

    // ---------------- second offer ignored while pending full ----------------
    step_to(100);
    data_in    = 32'hAAAA0000;
    data_valid = 1'b1;
    step_to(101);
    data_in    = 32'hBBBB0000;   // held valid across the boundary
    step_to(110); check("ready_full", {31'b0, data_ready}, 32'd0);
    step_to(128);
    check("disp_b1",   disp_data,           32'hAAAA0000);
    check("ready_b1",  {31'b0, data_ready}, 32'd1);
    step_to(129);
    data_valid = 1'b0;
    check("ready_c129", {31'b0, data_ready}, 32'd0);
    step_to(159); check("disp_c159", disp_data, 32'hAAAA0000);
    step_to(160); check("disp_b2",   disp_data, 32'hBBBB0000);

    // ---------------- data_valid exactly on a boundary cycle ----------------
    step_to(191);
    data_in    = 32'h33330033;
    data_valid = 1'b1;
    step_to(192);
    data_valid = 1'b0;
    check("disp_bnd",  disp_data,           32'hBBBB0000);
    check("fd_bnd",    {31'b0, frame_done}, 32'd1);
    check("ready_bnd", {31'b0, data_ready}, 32'd0);
    step_to(223); check("disp_c223", disp_data, 32'hBBBB0000);
    step_to(224);
    check("disp_next", disp_data,           32'h33330033);
    check("ready_c224", {31'b0, data_ready}, 32'd1);

    // ---------------- reset mid-frame with data pending ----------------
    step_to(230);
    data_in    = 32'h5555AAAA;
    data_valid = 1'b1;
    step_to(231);
    data_valid = 1'b0;
    step_to(245);
    check("led_pre_rst", {29'b0, LED_clk},    32'd5);
    check("pend_pre_rst", {31'b0, data_ready}, 32'd0);
    rst = 1'b1;
    step_to(246);
    check("mr_led",   {29'b0, LED_clk},    32'd0);
    check("mr_disp",  disp_data,           32'h0);
    check("mr_ready", {31'b0, data_ready}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    #1;
    check("mr_ready_rel", {31'b0, data_ready}, 32'd1);
    step_to(4);  check("mr_led_c4", {29'b0, LED_clk}, 32'd1);
    step_to(32);
    check("mr_disp_b", disp_data,           32'h0);
    check("mr_fd_b",   {31'b0, frame_done}, 32'd1);

`ifdef LED_SCAN_FREEZE_EN
    // ---------------- freeze across two boundaries ----------------
    step_to(39);
    data_in    = 32'hCAFE0001;
    data_valid = 1'b1;
    step_to(40);
    data_valid = 1'b0;
    step_to(41);
    freeze = 1'b1;
    step_to(64);
    check("fz_disp_b1",  disp_data,           32'h0);
    check("fz_fd_b1",    {31'b0, frame_done}, 32'd1);
    check("fz_ready_b1", {31'b0, data_ready}, 32'd0);
    step_to(96);
    check("fz_disp_b2",  disp_data,           32'h0);
    check("fz_fd_b2",    {31'b0, frame_done}, 32'd1);
    check("fz_led_b2",   {29'b0, LED_clk},    32'd0);
    step_to(100);
    freeze = 1'b0;
    step_to(127); check("fz_disp_c127", disp_data, 32'h0);
    step_to(128);
    check("fz_disp_b3",  disp_data,           32'hCAFE0001);
    check("fz_ready_b3", {31'b0, data_ready}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
